// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: instruction classes, packed control field,
// base opcodes and the fetch state encoding.
package rv32_pkg;

   typedef enum logic [2:0] {
      INST_R  = 3'd0,
      INST_I  = 3'd1,
      INST_S  = 3'd2,
      INST_SB = 3'd3,
      INST_UJ = 3'd4,
      INST_U  = 3'd5
   } inst_type_t;

   // Control field consumed by control_logic_unit: {funct7, funct3, opcode}.
   typedef struct packed {
      logic [6:0] funct7;
      logic [2:0] funct3;
      logic [6:0] opcode;
   } fop_t;

   typedef logic [31:0] b_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/inst_classifier.sv
// Combinational decode of a fetched word into its instruction class and the
// masked {funct7, funct3, opcode} control field.
module inst_classifier
   import rv32_pkg::*;
(
   input  logic [31:0] word,
   output inst_type_t  i_type,
   output fop_t        field,
   output logic        illegal_inst
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = word[6:0];
   assign funct3      = word[14:12];
   assign unused_bits = ^{word[24:15], word[11:7]};

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      i_type       = INST_R;
      illegal_inst = 1'b0;
      field        = '0;
      case (opcode)
         OP_R:                      i_type = INST_R;
         OP_LOAD, OP_IMM, OP_JALR:  i_type = INST_I;
         OP_STORE:                  i_type = INST_S;
         OP_BRANCH:                 i_type = INST_SB;
         OP_JAL:                    i_type = INST_UJ;
         OP_LUI, OP_AUIPC:          i_type = INST_U;
         default:                   illegal_inst = 1'b1;
      endcase
      if (!illegal_inst) begin
         field.opcode = opcode;
         field.funct3 = (i_type == INST_U || i_type == INST_UJ) ? 3'b000 : funct3;
         // Shift-immediates carry funct7 as an operation selector (SRLI vs SRAI).
         if (opcode == OP_R || (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)))
            field.funct7 = word[31:25];
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake with a timeout,
// and holds one classified instruction for decode under valid/ready.
module instruction_fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16,
   parameter int          TO_W     = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic        inst_valid,
   output logic [16:0] instruction,
   output logic [2:0]  i_type,
   output logic [31:0] inst_raw,
   output logic [31:0] inst_pc,
   output logic        illegal_inst,
   output logic        fetch_fault
);

   fetch_state_t    state;
   logic [31:0]     pc;
   logic [31:0]     addr_q;
   logic [TO_W-1:0] cnt;
   logic            drop;

   inst_type_t cls_type;
   fop_t       cls_field;
   logic       cls_illegal;

   inst_classifier u_classifier (
      .word         (imem_rdata),
      .i_type       (cls_type),
      .field        (cls_field),
      .illegal_inst (cls_illegal)
   );

   // The request is a pure decode of state, masked while reset is asserted.
   assign imem_req  = !rst && (state == ST_FETCH || state == ST_WAIT);
   assign imem_addr = (state == ST_FETCH) ? pc : addr_q;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state        <= ST_FETCH;
         pc           <= RESET_PC;
         addr_q       <= RESET_PC;
         cnt          <= '0;
         drop         <= 1'b0;
         inst_valid   <= 1'b0;
         instruction  <= '0;
         i_type       <= '0;
         inst_raw     <= '0;
         inst_pc      <= '0;
         illegal_inst <= 1'b0;
         fetch_fault  <= 1'b0;
      end else begin
         case (state)
            ST_FETCH, ST_WAIT: begin
               if (imem_ack) begin
                  cnt  <= '0;
                  drop <= 1'b0;
                  if (redirect_en || drop) begin
                     // Word belongs to the abandoned path: discard and refetch.
                     state <= ST_FETCH;
                     if (redirect_en) pc <= redirect_pc & ~32'd3;
                  end else begin
                     state        <= ST_HOLD;
                     inst_valid   <= 1'b1;
                     instruction  <= cls_field;
                     i_type       <= cls_type;
                     inst_raw     <= imem_rdata;
                     inst_pc      <= imem_addr;
                     illegal_inst <= cls_illegal;
                  end
               end else begin
                  if (redirect_en) begin
                     pc   <= redirect_pc & ~32'd3;
                     drop <= 1'b1;
                  end
                  if (state == ST_FETCH) begin
                     addr_q <= pc;
                     cnt    <= '0;
                     state  <= ST_WAIT;
                  end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                     fetch_fault <= 1'b1;
                     state       <= ST_HALT;
                  end else begin
                     cnt <= cnt + TO_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (redirect_en) begin
                  pc         <= redirect_pc & ~32'd3;
                  inst_valid <= 1'b0;
                  state      <= ST_FETCH;
               end else if (dec_ready) begin
                  pc         <= pc + 32'd4;
                  inst_valid <= 1'b0;
                  state      <= ST_FETCH;
               end
            end
            default: ; // ST_HALT: only reset leaves
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios pinned with literal expectations,
// then randomized traffic compared every cycle against a transaction model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        dec_ready = 1'b0;
   logic        inst_valid;
   logic [16:0] instruction;
   logic [2:0]  i_type;
   logic [31:0] inst_raw;
   logic [31:0] inst_pc;
   logic        illegal_inst;
   logic        fetch_fault;

   instruction_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .redirect_en  (redirect_en),
      .redirect_pc  (redirect_pc),
      .dec_ready    (dec_ready),
      .inst_valid   (inst_valid),
      .instruction  (instruction),
      .i_type       (i_type),
      .inst_raw     (inst_raw),
      .inst_pc      (inst_pc),
      .illegal_inst (illegal_inst),
      .fetch_fault  (fetch_fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          m_ready = 1'b0;
   bit          m_held, m_halted, m_outstanding, m_discard, m_fault;
   int          m_age;
   logic [31:0] m_pc, m_out_addr, m_raw, m_ipc;
   logic [16:0] m_field;
   logic [2:0]  m_type;
   bit          m_ill;

   function automatic void classify(input logic [31:0] w, output logic [16:0] f,
                                    output logic [2:0] t, output bit ill);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = w[6:0];
      f3 = w[14:12];
      f7 = 7'd0;
      ill = 1'b0;
      t = 3'd0;
      case (op)
         7'b0110011: t = 3'd0;
         7'b0000011, 7'b0010011, 7'b1100111: t = 3'd1;
         7'b0100011: t = 3'd2;
         7'b1100011: t = 3'd3;
         7'b1101111: t = 3'd4;
         7'b0110111, 7'b0010111: t = 3'd5;
         default: ill = 1'b1;
      endcase
      if (t == 3'd4 || t == 3'd5) f3 = 3'd0;
      if (op == 7'b0110011 || (op == 7'b0010011 && (w[14:12] == 3'b001 || w[14:12] == 3'b101)))
         f7 = w[31:25];
      f = ill ? 17'd0 : {f7, f3, op};
   endfunction

   always @(posedge clk) begin
      logic [31:0] a;
      if (rst) begin
         m_ready = 1'b1;
         m_pc = RESET_PC;
         m_held = 0; m_halted = 0; m_outstanding = 0; m_discard = 0; m_fault = 0;
         m_age = 0; m_out_addr = '0;
         m_raw = '0; m_ipc = '0; m_field = '0; m_type = '0; m_ill = 0;
      end else if (m_ready && !m_halted) begin
         if (m_held) begin
            if (redirect_en) begin
               m_pc = redirect_pc & 32'hFFFF_FFFC;
               m_held = 0;
            end else if (dec_ready) begin
               m_pc = m_pc + 32'd4;
               m_held = 0;
            end
         end else begin
            a = m_outstanding ? m_out_addr : m_pc;
            if (imem_ack) begin
               if (redirect_en || m_discard) begin
                  if (redirect_en) m_pc = redirect_pc & 32'hFFFF_FFFC;
               end else begin
                  m_held = 1;
                  m_raw = imem_rdata;
                  m_ipc = a;
                  classify(imem_rdata, m_field, m_type, m_ill);
               end
               m_discard = 0;
               m_outstanding = 0;
               m_age = 0;
            end else begin
               if (redirect_en) begin
                  m_discard = 1;
                  m_pc = redirect_pc & 32'hFFFF_FFFC;
               end
               if (!m_outstanding) begin
                  m_outstanding = 1;
                  m_out_addr = a;
                  m_age = 0;
               end else begin
                  m_age++;
                  if (m_age == TIMEOUT) begin
                     m_halted = 1;
                     m_fault = 1;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      bit exp_req;
      if (m_ready) begin
         exp_req = !rst && !m_held && !m_halted;
         check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
         if (exp_req)
            check("imem_addr", imem_addr, m_outstanding ? m_out_addr : m_pc);
         check("inst_valid", {31'd0, inst_valid}, {31'd0, m_held});
         check("instruction", {15'd0, instruction}, {15'd0, m_field});
         check("i_type", {29'd0, i_type}, {29'd0, m_type});
         check("inst_raw", inst_raw, m_raw);
         check("inst_pc", inst_pc, m_ipc);
         check("illegal_inst", {31'd0, illegal_inst}, {31'd0, m_ill});
         check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit r, input bit ren, input logic [31:0] rpc, input bit rdy);
      rst = r; redirect_en = ren; redirect_pc = rpc; dec_ready = rdy;
      #1;
   endtask

   task automatic clk_ack(input bit ackw, input logic [31:0] data);
      imem_ack = ackw & imem_req;
      imem_rdata = data;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_word();
      logic [6:0] ops [10];
      logic [31:0] w;
      ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0000000};
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      return w;
   endfunction

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] W_ADD = 32'h002081B3;
   localparam logic [31:0] W_LW  = 32'h0040A183;
   localparam logic [31:0] W_LUI = 32'h12345237;

   initial begin
      bit          r, ren, rdy, ackw;
      logic [31:0] rpc;

      @(negedge clk); #1;
      // Reset held for two cycles
      drive(1, 0, 0, 0); clk_ack(0, 0);
      drive(1, 0, 0, 0); clk_ack(0, 0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_fault", {31'd0, fetch_fault}, 32'd0);

      // Release and zero-wait fetch of an add
      drive(0, 0, 0, 0);
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0);
      clk_ack(1, W_ADD);
      check("add_valid", {31'd0, inst_valid}, 32'd1);
      check("add_field", {15'd0, instruction}, {15'd0, 17'b00000000000110011});
      check("add_type", {29'd0, i_type}, 32'd0);
      check("add_pc", inst_pc, 32'h0);
      drive(0, 0, 0, 1); clk_ack(0, 0);
      check("next_addr4", imem_addr, 32'h4);

      // Load with three wait cycles
      drive(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         clk_ack(0, 0);
         check("lw_addr_stable", imem_addr, 32'h4);
      end
      clk_ack(1, W_LW);
      check("lw_field", {15'd0, instruction}, {15'd0, 17'b00000000100000011});
      check("lw_type", {29'd0, i_type}, 32'd1);
      check("lw_pc", inst_pc, 32'h4);

      // Backpressure: frozen for five cycles, then advance by 4
      for (int i = 0; i < 5; i++) begin
         clk_ack(0, 0);
         check("bp_req", {31'd0, imem_req}, 32'd0);
         check("bp_raw", inst_raw, W_LW);
      end
      drive(0, 0, 0, 1); clk_ack(0, 0);
      check("bp_next_addr", imem_addr, 32'h8);

      // Redirect while waiting: the returned word is dropped
      drive(0, 0, 0, 0); clk_ack(0, 0);
      drive(0, 1, 32'h0000_0103, 0); clk_ack(0, 0);
      check("redir_addr_old", imem_addr, 32'h8);
      drive(0, 0, 0, 0); clk_ack(0, 0);
      clk_ack(1, W_ADD);
      check("redir_dropped", {31'd0, inst_valid}, 32'd0);
      check("redir_target", imem_addr, 32'h0000_0100);
      clk_ack(1, W_ADD);
      check("redir_pc", inst_pc, 32'h0000_0100);
      // Redirect in HOLD wins over dec_ready
      drive(0, 1, 32'h0000_0200, 1); clk_ack(0, 0);
      check("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
      check("hold_redir_addr", imem_addr, 32'h0000_0200);

      // Illegal word
      drive(0, 0, 0, 0); clk_ack(1, 32'hFFFF_FFFF);
      check("ill_flag", {31'd0, illegal_inst}, 32'd1);
      check("ill_field", {15'd0, instruction}, 32'd0);
      check("ill_type", {29'd0, i_type}, 32'd0);
      drive(0, 0, 0, 1); clk_ack(0, 0);
      check("ill_next_addr", imem_addr, 32'h0000_0204);

      // Timeout: one FETCH cycle plus TIMEOUT unacknowledged WAIT cycles
      drive(0, 0, 0, 0);
      for (int i = 0; i <= TIMEOUT; i++) begin
         clk_ack(0, 0);
         if (i == TIMEOUT - 1) check("pre_timeout_fault", {31'd0, fetch_fault}, 32'd0);
      end
      check("timeout_fault", {31'd0, fetch_fault}, 32'd1);
      check("timeout_req", {31'd0, imem_req}, 32'd0);
      drive(0, 1, 32'h0000_0300, 1); clk_ack(1, W_ADD);
      check("halt_ignores_redir", {31'd0, imem_req}, 32'd0);

      // Reset out of HALT, then PC wrap at the top of the address space
      drive(1, 0, 0, 0); clk_ack(0, 0);
      check("halt_rst_fault", {31'd0, fetch_fault}, 32'd0);
      drive(0, 1, 32'hFFFF_FFFF, 0); clk_ack(1, W_ADD);
      check("wrap_target", imem_addr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0); clk_ack(1, W_LUI);
      check("lui_field", {15'd0, instruction}, {15'd0, 17'h00037});
      check("lui_type", {29'd0, i_type}, 32'd5);
      check("lui_pc", inst_pc, 32'hFFFF_FFFC);
      drive(0, 0, 0, 1); clk_ack(0, 0);
      check("wrap_addr", imem_addr, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         r    = ($urandom_range(0, 299) == 0);
         ren  = ($urandom_range(0, 9) == 0);
         rdy  = ($urandom_range(0, 9) < 6);
         ackw = ($urandom_range(0, 1) == 1);
         rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         drive(r, ren, rpc, rdy);
         clk_ack(ackw, rand_word());
      end

      drive(0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
